f1_loader: RTL

- Write-side producer for the conv-layer-1 feature RAM.
- Accepts a 28x28 8-bit pixel stream over a valid/ready handshake.
- Writes a 32x32 frame into the RAM write port, inserting the 2-pixel zero border itself.
- One pixel per 32-bit word: pixel index i goes to byte address BASE_ADDR + 4*i, which matches the conv read side's {raddr, 2'b0} word addressing.

---
 rtl/f1_pkg.sv | 21 ++
 rtl/f1_pad_counter.sv | 58 +++++
 rtl/f1_loader.sv | 139 +++++++++++++
 3 files changed

// File: rtl/f1_pkg.sv
`default_nettype none
// f1_pkg: frame geometry and FSM encoding shared by the conv-layer-1 feature RAM loader.
// Revision: 1.0
package f1_pkg;

  localparam int IMG_W       = 28;
  localparam int PAD         = 2;
  localparam int OUT_W       = IMG_W + 2 * PAD;
  localparam int FRAME_WORDS = OUT_W * OUT_W;
  localparam int IN_PIXELS   = IMG_W * IMG_W;
  localparam int WORD_BYTES  = 4;
  localparam int IDX_W       = $clog2(FRAME_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } f1_state_t;

endpackage
`default_nettype wire

// File: rtl/f1_pad_counter.sv
`default_nettype none
// f1_pad_counter: row/column walk over the padded frame with linear index and border decode.
// Revision: 1.0
module f1_pad_counter
  import f1_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_advance,
  output logic [IDX_W-1:0] o_index,
  output logic             o_is_border,
  output logic             o_is_final,
  output logic             o_is_last_pix
);

  localparam int            CW        = $clog2(OUT_W);
  localparam logic [CW-1:0] C_LAST    = CW'(OUT_W - 1);
  localparam logic [CW-1:0] C_PAD     = CW'(PAD);
  localparam logic [CW-1:0] C_END     = CW'(PAD + IMG_W);
  localparam logic [CW-1:0] C_LAST_IN = CW'(PAD + IMG_W - 1);

  logic [CW-1:0]    r_row;
  logic [CW-1:0]    r_col;
  logic [IDX_W-1:0] r_idx;
  logic             w_col_wrap;

  assign w_col_wrap = (r_col == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
      r_idx <= '0;
    end else if (i_clear) begin
      r_row <= '0;
      r_col <= '0;
      r_idx <= '0;
    end else if (i_advance) begin
      if (w_col_wrap) begin
        r_col <= '0;
        r_row <= (r_row == C_LAST) ? '0 : r_row + CW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
      // Linear index tracks r*OUT_W+c directly so no multiplier is needed.
      r_idx <= o_is_final ? '0 : r_idx + IDX_W'(1);
    end
  end

  assign o_index       = r_idx;
  assign o_is_final    = w_col_wrap && (r_row == C_LAST);
  assign o_is_border   = (r_row < C_PAD) || (r_row >= C_END) ||
                         (r_col < C_PAD) || (r_col >= C_END);
  assign o_is_last_pix = (r_row == C_LAST_IN) && (r_col == C_LAST_IN);

endmodule
`default_nettype wire

// File: rtl/f1_loader.sv
`default_nettype none
// f1_loader: streams a 28x28 pixel image into the feature RAM as a zero-padded 32x32 frame.
// Revision: 1.0
module f1_loader
  import f1_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [7:0]  pix_data,
  input  logic        pix_last,
  output logic [3:0]  f1_wr_en,
  output logic [31:0] f1_waddr,
  output logic [31:0] f1_wdata
);

  localparam int ADDR_SH = $clog2(WORD_BYTES);

  f1_state_t        r_state;
  f1_state_t        w_next;
  logic             w_clear;
  logic             w_advance;
  logic             w_accept;
  logic             w_pix_ready;
  logic [IDX_W-1:0] w_index;
  logic             w_is_border;
  logic             w_is_final;
  logic             w_is_last_pix;

  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [3:0]       r_wr_en;
  logic [31:0]      r_waddr;
  logic [31:0]      r_wdata;

  f1_pad_counter u_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (w_clear),
    .i_advance    (w_advance),
    .o_index      (w_index),
    .o_is_border  (w_is_border),
    .o_is_final   (w_is_final),
    .o_is_last_pix(w_is_last_pix)
  );

  always_comb begin
    w_next      = r_state;
    w_clear     = 1'b0;
    w_advance   = 1'b0;
    w_accept    = 1'b0;
    w_pix_ready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next  = ST_FILL;
          w_clear = 1'b1;
        end
      end
      ST_FILL: begin
        if (w_is_border) begin
          w_advance = 1'b1;
        end else begin
          w_pix_ready = 1'b1;
          if (pix_valid) begin
            w_advance = 1'b1;
            w_accept  = 1'b1;
          end
        end
        if (w_advance && w_is_final) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // DONE coincides with the final write; done/busy are registered so they land one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= (r_state == ST_DONE);
      if (w_clear) begin
        r_busy <= 1'b1;
      end else if (r_state == ST_DONE) begin
        r_busy <= 1'b0;
      end
      if (w_clear) begin
        r_err <= 1'b0;
      end else if (w_accept && (pix_last != w_is_last_pix)) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_advance) begin
      r_wr_en <= 4'hF;
      r_waddr <= BASE_ADDR + (32'(w_index) << ADDR_SH);
      r_wdata <= {24'h0, (w_accept ? pix_data : 8'h00)};
    end else begin
      r_wr_en <= '0;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign pix_ready = w_pix_ready;
  assign f1_wr_en  = r_wr_en;
  assign f1_waddr  = r_waddr;
  assign f1_wdata  = r_wdata;

endmodule
`default_nettype wire
